dds_freq_ctrl: RTL and testbench

Control front end for the DDS signal generator: debounces the freq_add/freq_dec push-buttons, maintains a saturating frequency tuning word and a waveform selection, and hands both to the phase accumulator/ROM address datapath. Updates are committed only at a phase-accumulator wrap, so the output waveform never shows a mid-period discontinuity. Sits between the board buttons/switches and the address calculation block; it replaces direct button-to-register wiring.

---
 rtl/dds_freq_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_dds_freq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_freq_ctrl.sv
// dds_freq_ctrl: debounces the frequency buttons and keeps a saturating tuning word and a
// waveform select. Both are committed to the datapath only on a phase-accumulator wrap.
// Build option: define FREQ_AUTO_REPEAT_EN to enable auto-repeat on held buttons.
module dds_freq_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter logic [11:0] FREQ_INIT       = 12'd16,
  parameter logic [11:0] FREQ_MIN        = 12'd1,
  parameter logic [11:0] FREQ_MAX        = 12'd4095,
  parameter logic [11:0] FREQ_STEP       = 12'd1
) (
  input  logic        sys_clk_i,
  input  logic        reset_i,
  input  logic        freq_add_i,
  input  logic        freq_dec_i,
  input  logic [1:0]  switch_i,
  input  logic        phase_wrap_i,
  output logic [11:0] freq_word_o,
  output logic [1:0]  wave_sel_o,
  output logic        cfg_update_o
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

`ifdef FREQ_AUTO_REPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW = $clog2(RptMax + 1);
  localparam logic [RptW-1:0] RptDelayLast  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RptPeriodLast = RptW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} btn_state_e;
`else
  typedef enum logic {StIdle, StHold} btn_state_e;
`endif

  // Index 0 is the add button, index 1 the dec button.
  logic [1:0] btn_raw;
  assign btn_raw = {freq_dec_i, freq_add_i};

  logic [1:0] btn_s1_q, btn_s2_q;
  logic [1:0] sw_s1_q, sw_s2_q;

  // Two-flop synchronizers; the synchronized switch value is the pending waveform
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= switch_i;
      sw_s2_q  <= sw_s1_q;
    end
  end

  logic [1:0]          btn_db_q, btn_db_d;
  logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;

  // Debounce: accept a new level once it has differed from the current one long enough
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    for (int b = 0; b < 2; b++) begin
      if (btn_s2_q[b] != btn_db_q[b]) begin
        if (db_cnt_q[b] == DbLast) begin
          btn_db_d[b] = ~btn_db_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // Debounced level and stability counters
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      btn_db_q <= '0;
      db_cnt_q <= '0;
    end else begin
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  btn_state_e state_q [2];
  btn_state_e state_d [2];
  logic [1:0] step;

`ifdef FREQ_AUTO_REPEAT_EN
  logic [1:0][RptW-1:0] rpt_cnt_q, rpt_cnt_d;

  // Button FSMs: step on press, then after the hold delay, then every repeat period
  always_comb begin
    step      = '0;
    rpt_cnt_d = rpt_cnt_q;
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      unique case (state_q[b])
        StIdle: begin
          if (btn_db_q[b]) begin
            state_d[b]   = StHold;
            step[b]      = 1'b1;
            rpt_cnt_d[b] = '0;
          end
        end
        StHold: begin
          if (!btn_db_q[b]) begin
            state_d[b] = StIdle;
          end else if (rpt_cnt_q[b] == RptDelayLast) begin
            state_d[b]   = StRepeat;
            step[b]      = 1'b1;
            rpt_cnt_d[b] = '0;
          end else begin
            rpt_cnt_d[b] = rpt_cnt_q[b] + 1'b1;
          end
        end
        StRepeat: begin
          if (!btn_db_q[b]) begin
            state_d[b] = StIdle;
          end else if (rpt_cnt_q[b] == RptPeriodLast) begin
            step[b]      = 1'b1;
            rpt_cnt_d[b] = '0;
          end else begin
            rpt_cnt_d[b] = rpt_cnt_q[b] + 1'b1;
          end
        end
        default: state_d[b] = StIdle;
      endcase
    end
  end

  // Repeat timers
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  // Button FSMs: exactly one step per debounced press
  always_comb begin
    step = '0;
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      unique case (state_q[b])
        StIdle: begin
          if (btn_db_q[b]) begin
            state_d[b] = StHold;
            step[b]    = 1'b1;
          end
        end
        StHold: begin
          if (!btn_db_q[b]) begin
            state_d[b] = StIdle;
          end
        end
        default: state_d[b] = StIdle;
      endcase
    end
  end
`endif

  // Button FSM state registers
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= StIdle;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
      end
    end
  end

  logic [11:0] freq_pend_q, freq_pend_d;
  logic [11:0] freq_word_q, freq_word_d;
  logic [1:0]  wave_sel_q, wave_sel_d;
  logic        cfg_update_q, cfg_update_d;
  logic [12:0] inc_sum, dec_diff;
  logic        pending, commit;

  // Saturating step arithmetic and wrap-aligned commit; commit uses the pre-step pending value
  always_comb begin
    inc_sum  = {1'b0, freq_pend_q} + {1'b0, FREQ_STEP};
    dec_diff = {1'b0, freq_pend_q} - {1'b0, FREQ_STEP};

    freq_pend_d = freq_pend_q;
    if (step == 2'b01) begin
      freq_pend_d = (inc_sum > {1'b0, FREQ_MAX}) ? FREQ_MAX : inc_sum[11:0];
    end else if (step == 2'b10) begin
      // Bit 12 set means the subtraction borrowed.
      freq_pend_d = (dec_diff[12] || (dec_diff < {1'b0, FREQ_MIN})) ? FREQ_MIN : dec_diff[11:0];
    end

    pending      = (freq_pend_q != freq_word_q) || (sw_s2_q != wave_sel_q);
    commit       = phase_wrap_i && pending;
    freq_word_d  = commit ? freq_pend_q : freq_word_q;
    wave_sel_d   = commit ? sw_s2_q : wave_sel_q;
    cfg_update_d = commit;
  end

  // Pending and committed configuration registers
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      freq_pend_q  <= FREQ_INIT;
      freq_word_q  <= FREQ_INIT;
      wave_sel_q   <= 2'b00;
      cfg_update_q <= 1'b0;
    end else begin
      freq_pend_q  <= freq_pend_d;
      freq_word_q  <= freq_word_d;
      wave_sel_q   <= wave_sel_d;
      cfg_update_q <= cfg_update_d;
    end
  end

  assign freq_word_o  = freq_word_q;
  assign wave_sel_o   = wave_sel_q;
  assign cfg_update_o = cfg_update_q;

endmodule

// File: tb/tb_dds_freq_ctrl.sv
// Bench for dds_freq_ctrl: three instances (init 16, 4094, 1) share one stimulus stream and are
// checked every cycle against a cycle-level behavioural model, plus hand-computed literals.
`timescale 1ns/1ps
module tb_dds_freq_ctrl;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;
`ifdef FREQ_AUTO_REPEAT_EN
  localparam bit RepeatOn = 1'b1;
`else
  localparam bit RepeatOn = 1'b0;
`endif

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       add  = 1'b0;
  logic       dec  = 1'b0;
  logic       wrap = 1'b0;
  logic [1:0] sw   = 2'b00;

  logic [11:0] word [3];
  logic [1:0]  wave [3];
  logic        cfg  [3];

  int n_cmp = 0;
  int n_err = 0;
  int cfg_seen = 0;

  always #5 clk = ~clk;

  dds_freq_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                  .FREQ_INIT(12'd16)) u_dut_mid (
    .sys_clk_i(clk), .reset_i(rst), .freq_add_i(add), .freq_dec_i(dec), .switch_i(sw),
    .phase_wrap_i(wrap), .freq_word_o(word[0]), .wave_sel_o(wave[0]), .cfg_update_o(cfg[0]));

  dds_freq_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                  .FREQ_INIT(12'd4094)) u_dut_hi (
    .sys_clk_i(clk), .reset_i(rst), .freq_add_i(add), .freq_dec_i(dec), .switch_i(sw),
    .phase_wrap_i(wrap), .freq_word_o(word[1]), .wave_sel_o(wave[1]), .cfg_update_o(cfg[1]));

  dds_freq_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                  .FREQ_INIT(12'd1)) u_dut_lo (
    .sys_clk_i(clk), .reset_i(rst), .freq_add_i(add), .freq_dec_i(dec), .switch_i(sw),
    .phase_wrap_i(wrap), .freq_word_o(word[2]), .wave_sel_o(wave[2]), .cfg_update_o(cfg[2]));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_sync1 [2], m_sync2 [2], m_db [2], m_diff_run [2], m_held [2];
  int m_wsync1, m_wsync2;
  int m_pend [3], m_word [3], m_wave [3], m_cfg [3];

  function automatic int init_of(input int i);
    return (i == 0) ? 16 : (i == 1) ? 4094 : 1;
  endfunction

  // One rising edge of the clock, applied to the model.
  task automatic model_tick();
    bit st [2];
    int db_next;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_sync1[b] = 0; m_sync2[b] = 0; m_db[b] = 0; m_diff_run[b] = 0; m_held[b] = 0;
      end
      m_wsync1 = 0; m_wsync2 = 0;
      for (int i = 0; i < 3; i++) begin
        m_pend[i] = init_of(i); m_word[i] = init_of(i); m_wave[i] = 0; m_cfg[i] = 0;
      end
      return;
    end
    // Step events this cycle: press, then (optionally) RD cycles later, then every RP cycles.
    for (int b = 0; b < 2; b++) begin
      st[b] = (m_db[b] != 0) &&
              (m_held[b] == 0 ||
               (RepeatOn && m_held[b] >= RD && ((m_held[b] - RD) % RP) == 0));
    end
    for (int i = 0; i < 3; i++) begin
      m_cfg[i] = (wrap && (m_pend[i] != m_word[i] || m_wsync2 != m_wave[i])) ? 1 : 0;
      if (m_cfg[i] != 0) begin
        m_word[i] = m_pend[i];
        m_wave[i] = m_wsync2;
      end
      if (st[0] && !st[1]) m_pend[i] = (m_pend[i] + 1 > 4095) ? 4095 : m_pend[i] + 1;
      else if (st[1] && !st[0]) m_pend[i] = (m_pend[i] - 1 < 1) ? 1 : m_pend[i] - 1;
    end
    for (int b = 0; b < 2; b++) begin
      db_next = m_db[b];
      if (m_sync2[b] != m_db[b]) begin
        m_diff_run[b]++;
        if (m_diff_run[b] == D) begin
          db_next = 1 - m_db[b];
          m_diff_run[b] = 0;
        end
      end else begin
        m_diff_run[b] = 0;
      end
      m_held[b] = (m_db[b] != 0 && db_next != 0) ? m_held[b] + 1 : 0;
      m_db[b] = db_next;
      m_sync2[b] = m_sync1[b];
    end
    m_sync1[0] = add;
    m_sync1[1] = dec;
    m_wsync2 = m_wsync1;
    m_wsync1 = sw;
  endtask

  // Compare process: every cycle, just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      model_tick();
      #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_word[%0d]", i), int'(word[i]), m_word[i]);
        chk($sformatf("model_wave[%0d]", i), int'(wave[i]), m_wave[i]);
        chk($sformatf("model_cfg[%0d]", i), int'(cfg[i]), m_cfg[i]);
      end
      if (cfg[0]) cfg_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    add = 1'b0; dec = 1'b0; wrap = 1'b0; sw = 2'b00;
    cyc(2);
    rst = 1'b0;
    cyc(2);
  endtask

  // Wrap pulse covering one active edge; returns at the negedge right after the commit edge.
  task automatic pulse_wrap();
    @(negedge clk);
    wrap = 1'b1;
    @(negedge clk);
    wrap = 1'b0;
  endtask

  // Raw press held for n sampled edges, then released and left to settle.
  task automatic press(input bit do_add, input bit do_dec, input int n);
    @(negedge clk);
    add = do_add; dec = do_dec;
    cyc(n);
    add = 1'b0; dec = 1'b0;
    cyc(12);
  endtask

  int c0;
  int hold_a, hold_d;

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // Nothing pending: a wrap must not commit.
    chk("reset_word", int'(word[0]), 16);
    chk("reset_wave", int'(wave[0]), 0);
    chk("reset_cfg", int'(cfg[0]), 0);
    c0 = cfg_seen;
    pulse_wrap();
    cyc(3);
    chk("idle_wrap_word", int'(word[0]), 16);
    chk("idle_wrap_cfg_pulses", cfg_seen - c0, 0);

    // 3-cycle glitch on dec is shorter than the debounce window.
    @(negedge clk);
    dec = 1'b1;
    cyc(3);
    dec = 1'b0;
    cyc(20);
    c0 = cfg_seen;
    pulse_wrap();
    cyc(3);
    chk("glitch_word", int'(word[0]), 16);
    chk("glitch_cfg_pulses", cfg_seen - c0, 0);

    // Short dec press: one step; the low instance stays clamped at 1.
    press(1'b0, 1'b1, 6);
    pulse_wrap();
    chk("dec_mid_word", int'(word[0]), 15);
    chk("dec_hi_word", int'(word[1]), 4093);
    chk("dec_lo_word", int'(word[2]), 1);

    // Add held long enough for press + two repeats (debounced level high 16 cycles).
    do_reset();
    c0 = cfg_seen;
    press(1'b1, 1'b0, 16);
    pulse_wrap();
    chk("hold_word", int'(word[0]), RepeatOn ? 19 : 17);
    chk("hold_cfg_now", int'(cfg[0]), 1);
    chk("hold_hi_sat", int'(word[1]), 4095);
    cyc(1);
    chk("hold_cfg_after", int'(cfg[0]), 0);
    cyc(5);
    chk("hold_cfg_pulses", cfg_seen - c0, 1);

    // Two single presses from 4094 saturate at 4095.
    do_reset();
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b0, 6);
    pulse_wrap();
    chk("two_add_hi", int'(word[1]), 4095);
    chk("two_add_mid", int'(word[0]), 18);

    // Simultaneous presses cancel; switch waits for a wrap.
    do_reset();
    press(1'b1, 1'b1, 6);
    @(negedge clk);
    sw = 2'b10;
    cyc(100);
    chk("sw_no_wrap", int'(wave[0]), 0);
    chk("both_word", int'(word[0]), 16);
    pulse_wrap();
    chk("sw_wave", int'(wave[0]), 2);
    chk("sw_cfg_now", int'(cfg[0]), 1);
    chk("sw_both_word", int'(word[0]), 16);
    cyc(1);
    chk("sw_cfg_after", int'(cfg[0]), 0);

    // Reset with a step pending discards it immediately.
    do_reset();
    press(1'b1, 1'b0, 6);
    pulse_wrap();
    chk("pre_rst_word", int'(word[0]), 17);
    press(1'b1, 1'b0, 6);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_word", int'(word[0]), 16);
    chk("async_rst_cfg", int'(cfg[0]), 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    c0 = cfg_seen;
    pulse_wrap();
    cyc(2);
    chk("post_rst_word", int'(word[0]), 16);
    chk("post_rst_cfg_pulses", cfg_seen - c0, 0);

    // Randomized traffic, checked by the model every cycle.
    hold_a = 0;
    hold_d = 0;
    repeat (4000) begin
      @(negedge clk);
      if (hold_a == 0) begin
        add = 1'($urandom_range(0, 1));
        hold_a = $urandom_range(1, 28);
      end else begin
        hold_a--;
      end
      if (hold_d == 0) begin
        dec = 1'($urandom_range(0, 1));
        hold_d = $urandom_range(1, 28);
      end else begin
        hold_d--;
      end
      if ($urandom_range(0, 40) == 0) sw = 2'($urandom_range(0, 3));
      wrap = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 500) == 0);
    end
    @(negedge clk);
    rst = 1'b0; wrap = 1'b0; add = 1'b0; dec = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
